footsies_round_ctrl: RTL and testbench

Match/round sequencer for the two-player footsies game. Sits above the two per-player sprite state machines: holds them in reset outside live play, integrates their movement states into on-screen positions, resolves attack hits and clashes, keeps score and steps the match through countdown, fight, hit-stop and round-end phases.

---
 rtl/footsies_round_ctrl_pkg.sv | 66 ++++++
 rtl/footsies_round_ctrl_frame_timer.sv | 35 +++
 rtl/footsies_round_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_footsies_round_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/footsies_round_ctrl_pkg.sv
// Shared types and tuning constants for the footsies match/round sequencer.
// Optional round time limit is enabled by defining FOOTSIES_ROUND_TIMEOUT_EN.
package footsies_round_ctrl_pkg;

    typedef enum logic [2:0] {
        SPR_IDLE         = 3'd0,
        SPR_BACKWARD     = 3'd1,
        SPR_FORWARD      = 3'd2,
        SPR_ATK_START    = 3'd3,
        SPR_ATK_ACTIVE   = 3'd4,
        SPR_ATK_RECOVERY = 3'd5
    } sprite_state_e;

    typedef enum logic [2:0] {
        PH_IDLE       = 3'd0,
        PH_COUNTDOWN  = 3'd1,
        PH_FIGHT      = 3'd2,
        PH_HITSTOP    = 3'd3,
        PH_ROUND_END  = 3'd4,
        PH_MATCH_OVER = 3'd5
    } phase_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    typedef logic [9:0]         pos_t;
    typedef logic signed [11:0] spos_t;

    localparam spos_t X_MIN      = 12'sd16;
    localparam spos_t X_MAX      = 12'sd623;
    localparam spos_t WALK_SPEED = 12'sd2;
    localparam spos_t MIN_GAP    = 12'sd32;
    localparam spos_t HIT_RANGE  = 12'sd64;
    localparam spos_t KNOCKBACK  = 12'sd24;

    localparam pos_t P1_START_X = 10'd200;
    localparam pos_t P2_START_X = 10'd440;

    localparam int TIMER_W = 7;
    typedef logic [TIMER_W-1:0] frames_t;

    localparam frames_t COUNTDOWN_FRAMES = 7'd60;
    localparam frames_t HITSTOP_FRAMES   = 7'd12;
    localparam frames_t ROUND_END_FRAMES = 7'd90;

    localparam logic [1:0]  WIN_ROUNDS   = 2'd3;
    localparam logic [10:0] ROUND_FRAMES = 11'd1800;

    function automatic spos_t to_spos(input pos_t p);
        return $signed({2'b00, p});
    endfunction

    function automatic pos_t clamp_x(input spos_t v);
        pos_t r;
        if (v < X_MIN) begin
            r = X_MIN[9:0];
        end else if (v > X_MAX) begin
            r = X_MAX[9:0];
        end else begin
            r = v[9:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/footsies_round_ctrl_frame_timer.sv
// Loadable frame-tick down-counter; done_o flags the tick that ends the loaded duration.
module footsies_round_ctrl_frame_timer
    import footsies_round_ctrl_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    load_i,
    input  frames_t load_val_i,
    input  logic    tick_i,
    output logic    done_o
);

    frames_t count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - frames_t'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A load of N expires on the N-th tick after the load.
    assign done_o = tick_i && (count_q <= frames_t'(1));

endmodule

// File: rtl/footsies_round_ctrl.sv
// Two-player footsies match sequencer: phases, positions, hit resolution and scoring.
// Define FOOTSIES_ROUND_TIMEOUT_EN to add the per-round time limit (draw on expiry).
module footsies_round_ctrl
    import footsies_round_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        frame_tick_i,
    input  logic        start_i,
    input  logic [2:0]  p1_state_i,
    input  logic [2:0]  p2_state_i,
    output logic        fsm_reset_o,
    output logic [2:0]  phase_o,
    output logic [9:0]  p1_x_o,
    output logic [9:0]  p2_x_o,
    output logic [1:0]  p1_score_o,
    output logic [1:0]  p2_score_o,
    output logic [1:0]  round_winner_o,
    output logic        match_over_o,
    output logic [10:0] round_timer_o
);

    phase_e     phase_q, phase_d;
    logic       fsm_reset_q, match_over_q, clash_q, clash_d;
    pos_t       p1_x_q, p1_x_d, p2_x_q, p2_x_d;
    logic [1:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
    logic [1:0] winner_q, winner_d;

    logic    tmr_load, tmr_done;
    frames_t tmr_val;
    logic    time_up;

    spos_t p1_cur, p2_cur, gap_cur, gap_prop;
    spos_t p1_fwd, p1_back, p2_fwd, p2_back;
    pos_t  p1_prop, p2_prop, p1_mv, p2_mv;
    logic  hit1, hit2;

    footsies_round_ctrl_frame_timer u_timer (
        .clk_i      (clk_i),
        .rst_i      (reset_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tick_i     (frame_tick_i),
        .done_o     (tmr_done)
    );

`ifdef FOOTSIES_ROUND_TIMEOUT_EN
    logic [10:0] round_timer_q, round_timer_d;

    always_comb begin
        round_timer_d = round_timer_q;
        time_up       = 1'b0;
        if (phase_q == PH_COUNTDOWN && frame_tick_i && tmr_done) begin
            round_timer_d = ROUND_FRAMES;
        end else if (phase_q == PH_FIGHT && frame_tick_i) begin
            round_timer_d = (round_timer_q == '0) ? '0 : round_timer_q - 11'd1;
            time_up       = (round_timer_q <= 11'd1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            round_timer_q <= '0;
        end else begin
            round_timer_q <= round_timer_d;
        end
    end

    assign round_timer_o = round_timer_q;
`else
    assign time_up       = 1'b0;
    assign round_timer_o = '0;
`endif

    // Walking: forward steps that would close the gap below MIN_GAP are dropped.
    always_comb begin
        p1_cur  = to_spos(p1_x_q);
        p2_cur  = to_spos(p2_x_q);
        gap_cur = p2_cur - p1_cur;
        hit1    = (p1_state_i == SPR_ATK_ACTIVE) && (gap_cur <= HIT_RANGE);
        hit2    = (p2_state_i == SPR_ATK_ACTIVE) && (gap_cur <= HIT_RANGE);

        p1_fwd  = (p1_state_i == SPR_FORWARD)  ? WALK_SPEED : '0;
        p1_back = (p1_state_i == SPR_BACKWARD) ? WALK_SPEED : '0;
        p2_fwd  = (p2_state_i == SPR_FORWARD)  ? WALK_SPEED : '0;
        p2_back = (p2_state_i == SPR_BACKWARD) ? WALK_SPEED : '0;

        p1_prop  = clamp_x(p1_cur + p1_fwd - p1_back);
        p2_prop  = clamp_x(p2_cur - p2_fwd + p2_back);
        gap_prop = to_spos(p2_prop) - to_spos(p1_prop);

        if (gap_prop < MIN_GAP) begin
            p1_mv = clamp_x(p1_cur - p1_back);
            p2_mv = clamp_x(p2_cur + p2_back);
        end else begin
            p1_mv = p1_prop;
            p2_mv = p2_prop;
        end
    end

    always_comb begin
        phase_d    = phase_q;
        p1_x_d     = p1_x_q;
        p2_x_d     = p2_x_q;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        winner_d   = winner_q;
        clash_d    = clash_q;
        tmr_load   = 1'b0;
        tmr_val    = COUNTDOWN_FRAMES;

        unique case (phase_q)
            PH_IDLE, PH_MATCH_OVER: begin
                if (start_i) begin
                    phase_d    = PH_COUNTDOWN;
                    p1_score_d = '0;
                    p2_score_d = '0;
                    p1_x_d     = P1_START_X;
                    p2_x_d     = P2_START_X;
                    tmr_load   = 1'b1;
                    tmr_val    = COUNTDOWN_FRAMES;
                end
            end
            PH_COUNTDOWN: begin
                if (frame_tick_i && tmr_done) begin
                    phase_d  = PH_FIGHT;
                    winner_d = WIN_NONE;
                end
            end
            PH_FIGHT: begin
                if (frame_tick_i) begin
                    if (hit1 && hit2) begin
                        p1_x_d   = clamp_x(p1_cur - KNOCKBACK);
                        p2_x_d   = clamp_x(p2_cur + KNOCKBACK);
                        clash_d  = 1'b1;
                        phase_d  = PH_HITSTOP;
                        tmr_load = 1'b1;
                        tmr_val  = HITSTOP_FRAMES;
                    end else if (hit1 || hit2) begin
                        p1_score_d = hit1 ? p1_score_q + 2'd1 : p1_score_q;
                        p2_score_d = hit2 ? p2_score_q + 2'd1 : p2_score_q;
                        winner_d   = hit1 ? WIN_P1 : WIN_P2;
                        clash_d    = 1'b0;
                        phase_d    = PH_HITSTOP;
                        tmr_load   = 1'b1;
                        tmr_val    = HITSTOP_FRAMES;
                    end else if (time_up) begin
                        winner_d = WIN_NONE;
                        phase_d  = PH_ROUND_END;
                        tmr_load = 1'b1;
                        tmr_val  = ROUND_END_FRAMES;
                    end else begin
                        p1_x_d = p1_mv;
                        p2_x_d = p2_mv;
                    end
                end
            end
            PH_HITSTOP: begin
                if (frame_tick_i && tmr_done) begin
                    if (clash_q) begin
                        phase_d = PH_FIGHT;
                    end else begin
                        phase_d  = PH_ROUND_END;
                        tmr_load = 1'b1;
                        tmr_val  = ROUND_END_FRAMES;
                    end
                end
            end
            PH_ROUND_END: begin
                if (frame_tick_i && tmr_done) begin
                    if (p1_score_q == WIN_ROUNDS || p2_score_q == WIN_ROUNDS) begin
                        phase_d = PH_MATCH_OVER;
                    end else begin
                        phase_d  = PH_COUNTDOWN;
                        p1_x_d   = P1_START_X;
                        p2_x_d   = P2_START_X;
                        tmr_load = 1'b1;
                        tmr_val  = COUNTDOWN_FRAMES;
                    end
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            phase_q      <= PH_IDLE;
            fsm_reset_q  <= 1'b1;
            match_over_q <= 1'b0;
            clash_q      <= 1'b0;
            p1_x_q       <= P1_START_X;
            p2_x_q       <= P2_START_X;
            p1_score_q   <= '0;
            p2_score_q   <= '0;
            winner_q     <= WIN_NONE;
        end else begin
            phase_q      <= phase_d;
            fsm_reset_q  <= (phase_d != PH_FIGHT);
            match_over_q <= (phase_d == PH_MATCH_OVER);
            clash_q      <= clash_d;
            p1_x_q       <= p1_x_d;
            p2_x_q       <= p2_x_d;
            p1_score_q   <= p1_score_d;
            p2_score_q   <= p2_score_d;
            winner_q     <= winner_d;
        end
    end

    assign phase_o        = phase_q;
    assign fsm_reset_o    = fsm_reset_q;
    assign match_over_o   = match_over_q;
    assign p1_x_o         = p1_x_q;
    assign p2_x_o         = p2_x_q;
    assign p1_score_o     = p1_score_q;
    assign p2_score_o     = p2_score_q;
    assign round_winner_o = winner_q;

endmodule

// File: tb/tb_footsies_round_ctrl.sv
// Bench for footsies_round_ctrl (default build): directed scenarios plus random play vs a behavioural model.
module tb_footsies_round_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  p1_st = 3'd0;
    logic [2:0]  p2_st = 3'd0;
    logic        fsm_reset;
    logic [2:0]  phase;
    logic [9:0]  p1_x, p2_x;
    logic [1:0]  p1_score, p2_score, round_winner;
    logic        match_over;
    logic [10:0] round_timer;

    int checks = 0;
    int errors = 0;

    footsies_round_ctrl dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .frame_tick_i   (frame_tick),
        .start_i        (start),
        .p1_state_i     (p1_st),
        .p2_state_i     (p2_st),
        .fsm_reset_o    (fsm_reset),
        .phase_o        (phase),
        .p1_x_o         (p1_x),
        .p2_x_o         (p2_x),
        .p1_score_o     (p1_score),
        .p2_score_o     (p2_score),
        .round_winner_o (round_winner),
        .match_over_o   (match_over),
        .round_timer_o  (round_timer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase number, positions, scores, ticks left in the timed phase.
    int m_phase = 0, m_p1 = 200, m_p2 = 440, m_s1 = 0, m_s2 = 0, m_win = 0, m_left = 0;
    bit m_clash = 1'b0;

    function automatic int clampi(input int v);
        return (v < 16) ? 16 : ((v > 623) ? 623 : v);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_p1 = 200; m_p2 = 440; m_s1 = 0; m_s2 = 0; m_win = 0; m_left = 0; m_clash = 0;
    endtask

    task automatic model_step();
        int gap, n1, n2, d1, d2;
        bit h1, h2;
        if (m_phase == 0 || m_phase == 5) begin
            if (start) begin
                m_phase = 1; m_s1 = 0; m_s2 = 0; m_p1 = 200; m_p2 = 440; m_left = 60;
            end
        end else if (frame_tick) begin
            if (m_phase == 2) begin
                gap = m_p2 - m_p1;
                h1 = (p1_st == 3'd4) && (gap <= 64);
                h2 = (p2_st == 3'd4) && (gap <= 64);
                if (h1 && h2) begin
                    m_p1 = clampi(m_p1 - 24); m_p2 = clampi(m_p2 + 24);
                    m_clash = 1; m_phase = 3; m_left = 12;
                end else if (h1 || h2) begin
                    if (h1) begin m_s1++; m_win = 1; end
                    else    begin m_s2++; m_win = 2; end
                    m_clash = 0; m_phase = 3; m_left = 12;
                end else begin
                    d1 = (p1_st == 3'd2) ? 2 : ((p1_st == 3'd1) ? -2 : 0);
                    d2 = (p2_st == 3'd2) ? -2 : ((p2_st == 3'd1) ? 2 : 0);
                    n1 = clampi(m_p1 + d1);
                    n2 = clampi(m_p2 + d2);
                    if (n2 - n1 < 32) begin
                        if (p1_st == 3'd2) n1 = m_p1;
                        if (p2_st == 3'd2) n2 = m_p2;
                    end
                    m_p1 = n1; m_p2 = n2;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (m_phase == 1) begin
                        m_phase = 2; m_win = 0;
                    end else if (m_phase == 3) begin
                        if (m_clash) m_phase = 2;
                        else begin m_phase = 4; m_left = 90; end
                    end else if (m_phase == 4) begin
                        if (m_s1 == 3 || m_s2 == 3) m_phase = 5;
                        else begin m_phase = 1; m_left = 60; m_p1 = 200; m_p2 = 440; end
                    end
                end
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge clk) begin
        chk("phase", phase, m_phase);
        chk("fsm_reset", fsm_reset, (m_phase != 2) ? 1 : 0);
        chk("p1_x", p1_x, m_p1);
        chk("p2_x", p2_x, m_p2);
        chk("p1_score", p1_score, m_s1);
        chk("p2_score", p2_score, m_s2);
        chk("round_winner", round_winner, m_win);
        chk("match_over", match_over, (m_phase == 5) ? 1 : 0);
        chk("round_timer", round_timer, 0);
    end

    task automatic step(input bit s, input bit t, input logic [2:0] a, input logic [2:0] b);
        start = s; frame_tick = t; p1_st = a; p2_st = b;
        @(negedge clk);
    endtask

    task automatic tick_until(input int want, input int budget);
        int n = 0;
        while (int'(phase) != want && n < budget) begin
            step(0, 1, 3'd0, 3'd0);
            n++;
        end
        chk("wait_phase", phase, want);
    endtask

    task automatic win_round_p1(input int end_phase);
        int n = 0;
        tick_until(2, 100);
        while ((int'(p2_x) - int'(p1_x)) > 64 && n < 300) begin
            step(0, 1, 3'd2, 3'd0);
            n++;
        end
        step(0, 1, 3'd4, 3'd0);
        chk("win_hitstop", phase, 3);
        n = 0;
        while (int'(phase) != end_phase && n < 300) begin
            step(0, 1, 3'd0, 3'd0);
            n++;
        end
        chk("win_end_phase", phase, end_phase);
    endtask

    initial begin
        int r;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_phase", phase, 0);
        chk("rst_fsm_reset", fsm_reset, 1);
        chk("rst_p1_x", p1_x, 200);
        chk("rst_p2_x", p2_x, 440);

        // Countdown length, then FIGHT; walk to 300 and reset asynchronously mid-cycle.
        step(1, 1, 3'd0, 3'd0);
        chk("cd_enter", phase, 1);
        repeat (59) step(0, 1, 3'd0, 3'd0);
        chk("cd_tick59", phase, 1);
        step(0, 1, 3'd0, 3'd0);
        chk("cd_fight", phase, 2);
        chk("cd_fsm_reset", fsm_reset, 0);
        repeat (50) step(0, 1, 3'd2, 3'd0);
        chk("walk_300", p1_x, 300);
        #1 rst = 1'b1;
        #1;
        chk("async_phase", phase, 0);
        chk("async_p1_x", p1_x, 200);
        chk("async_fsm_reset", fsm_reset, 1);
        @(negedge clk);
        rst = 1'b0;

        // Forward walk stops at the minimum gap.
        step(1, 1, 3'd0, 3'd0);
        repeat (60) step(0, 1, 3'd0, 3'd0);
        repeat (110) step(0, 1, 3'd2, 3'd0);
        chk("gap_stop_p1", p1_x, 408);
        chk("gap_stop_p2", p2_x, 440);
        step(0, 0, 3'd2, 3'd0);
        chk("no_tick_hold", p1_x, 408);

        // Clash at gap 50.
        repeat (9) step(0, 1, 3'd0, 3'd1);
        chk("p2_back", p2_x, 458);
        step(0, 1, 3'd4, 3'd4);
        chk("clash_p1", p1_x, 384);
        chk("clash_p2", p2_x, 482);
        chk("clash_phase", phase, 3);
        chk("clash_score", p1_score, 0);
        repeat (11) step(0, 1, 3'd0, 3'd0);
        chk("clash_hs11", phase, 3);
        step(0, 1, 3'd0, 3'd0);
        chk("clash_back", phase, 2);

        // Single hit at gap 60.
        repeat (19) step(0, 1, 3'd2, 3'd0);
        chk("approach_p1", p1_x, 422);
        step(0, 1, 3'd4, 3'd0);
        chk("hit_score", p1_score, 1);
        chk("hit_winner", round_winner, 1);
        repeat (11) step(0, 1, 3'd0, 3'd0);
        chk("hit_hs11", phase, 3);
        step(0, 1, 3'd0, 3'd0);
        chk("hit_round_end", phase, 4);
        repeat (89) step(0, 1, 3'd0, 3'd0);
        chk("re_tick89", phase, 4);
        step(0, 1, 3'd0, 3'd0);
        chk("re_countdown", phase, 1);
        chk("re_p1_reset", p1_x, 200);

        // Two more P1 rounds end the match; start restarts it.
        win_round_p1(1);
        win_round_p1(5);
        chk("mo_flag", match_over, 1);
        chk("mo_score", p1_score, 3);
        step(1, 0, 3'd0, 3'd0);
        chk("restart_phase", phase, 1);
        chk("restart_score", p1_score, 0);
        chk("restart_mo", match_over, 0);

        // Random play, weighted toward approaching and attacking.
        for (int i = 0; i < 20000; i++) begin
            if (i == 9000) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            r = $urandom_range(0, 9);
            p1_st = (r < 4) ? 3'd2 : (r == 4) ? 3'd1 : (r == 5) ? 3'd0 : (r < 8) ? 3'd4 : (r == 8) ? 3'd3 : 3'd5;
            r = $urandom_range(0, 9);
            p2_st = (r < 4) ? 3'd2 : (r == 4) ? 3'd1 : (r == 5) ? 3'd0 : (r < 8) ? 3'd4 : (r == 8) ? 3'd3 : 3'd5;
            frame_tick = ($urandom_range(0, 1) == 1);
            start = ($urandom_range(0, 39) == 0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
